cpu7_lsu: RTL

Load/store unit directly downstream of the EXU control stage. Accepts one memory operation per `_e` dispatch (base, offset, store data, destination), computes and checks the address, runs a two-phase request/response transaction on the data bus, and returns the aligned, extended load result (or a store completion) as a one-cycle `_m` pulse. The EXU writeback mux and its LSU stall logic consume that pulse. One operation is outstanding at a time.

---
 rtl/cpu7_lsu_pkg.sv | 36 +++
 rtl/cpu7_lsu_align.sv | 72 +++++++
 rtl/cpu7_lsu.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/cpu7_lsu_pkg.sv
// cpu7_lsu_pkg: LSU opcode and bus size encodings, FSM states (Rev 1.0)
`default_nettype none

package cpu7_lsu_pkg;

  localparam int LSU_CODE_BIT = 4;

  localparam logic [LSU_CODE_BIT-1:0] LSOC1K_LSU_LD_B  = 4'd0;
  localparam logic [LSU_CODE_BIT-1:0] LSOC1K_LSU_LD_H  = 4'd1;
  localparam logic [LSU_CODE_BIT-1:0] LSOC1K_LSU_LD_W  = 4'd2;
  localparam logic [LSU_CODE_BIT-1:0] LSOC1K_LSU_LD_BU = 4'd3;
  localparam logic [LSU_CODE_BIT-1:0] LSOC1K_LSU_LD_HU = 4'd4;
  localparam logic [LSU_CODE_BIT-1:0] LSOC1K_LSU_ST_B  = 4'd5;
  localparam logic [LSU_CODE_BIT-1:0] LSOC1K_LSU_ST_H  = 4'd6;
  localparam logic [LSU_CODE_BIT-1:0] LSOC1K_LSU_ST_W  = 4'd7;

  localparam logic [1:0] LSU_SIZE_B = 2'd0;
  localparam logic [1:0] LSU_SIZE_H = 2'd1;
  localparam logic [1:0] LSU_SIZE_W = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_e;

  function automatic logic op_is_load(input logic [LSU_CODE_BIT-1:0] op);
    return (op == LSOC1K_LSU_LD_B)  || (op == LSOC1K_LSU_LD_H) ||
           (op == LSOC1K_LSU_LD_W)  || (op == LSOC1K_LSU_LD_BU) ||
           (op == LSOC1K_LSU_LD_HU);
  endfunction

endpackage

`default_nettype wire

// File: rtl/cpu7_lsu_align.sv
// cpu7_lsu_align: store lane replication / byte strobes and load shift / extend (Rev 1.0)
`default_nettype none

module cpu7_lsu_align
  import cpu7_lsu_pkg::*;
#(
  parameter int GRLEN = 32
) (
  input  logic [LSU_CODE_BIT-1:0] st_op,
  input  logic [1:0]              st_addr_lo,
  input  logic [GRLEN-1:0]        st_wdata,
  output logic [GRLEN-1:0]        lane_wdata,
  output logic [3:0]              lane_wstrb,
  output logic [1:0]              size,
  output logic                    is_load,
  output logic                    misaligned,
  input  logic [LSU_CODE_BIT-1:0] ld_op,
  input  logic [1:0]              ld_addr_lo,
  input  logic [GRLEN-1:0]        rdata,
  output logic [GRLEN-1:0]        ld_result
);

  logic [GRLEN-1:0] shifted;

  always_comb begin
    lane_wdata = '0;
    lane_wstrb = 4'b0000;
    size       = LSU_SIZE_W;
    is_load    = op_is_load(st_op);
    case (st_op)
      LSOC1K_LSU_LD_B, LSOC1K_LSU_LD_BU: size = LSU_SIZE_B;
      LSOC1K_LSU_LD_H, LSOC1K_LSU_LD_HU: size = LSU_SIZE_H;
      LSOC1K_LSU_LD_W:                   size = LSU_SIZE_W;
      LSOC1K_LSU_ST_B: begin
        size       = LSU_SIZE_B;
        lane_wdata = GRLEN'({4{st_wdata[7:0]}});
        lane_wstrb = 4'b0001 << st_addr_lo;
      end
      LSOC1K_LSU_ST_H: begin
        size       = LSU_SIZE_H;
        lane_wdata = GRLEN'({2{st_wdata[15:0]}});
        lane_wstrb = 4'b0011 << st_addr_lo;
      end
      LSOC1K_LSU_ST_W: begin
        size       = LSU_SIZE_W;
        lane_wdata = st_wdata;
        lane_wstrb = 4'b1111;
      end
      default: ;
    endcase
    misaligned = ((size == LSU_SIZE_H) && st_addr_lo[0]) ||
                 ((size == LSU_SIZE_W) && (st_addr_lo != 2'b00));
  end

  // Bring the addressed byte lane down to bit 0 before extending.
  assign shifted = rdata >> {ld_addr_lo, 3'b000};

  always_comb begin
    ld_result = '0;
    case (ld_op)
      LSOC1K_LSU_LD_B:  ld_result = {{(GRLEN-8){shifted[7]}}, shifted[7:0]};
      LSOC1K_LSU_LD_H:  ld_result = {{(GRLEN-16){shifted[15]}}, shifted[15:0]};
      LSOC1K_LSU_LD_BU: ld_result = {{(GRLEN-8){1'b0}}, shifted[7:0]};
      LSOC1K_LSU_LD_HU: ld_result = {{(GRLEN-16){1'b0}}, shifted[15:0]};
      LSOC1K_LSU_LD_W:  ld_result = shifted;
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/cpu7_lsu.sv
// cpu7_lsu: single-outstanding load/store unit between EXU dispatch and the data bus (Rev 1.0)
`default_nettype none

module cpu7_lsu
  import cpu7_lsu_pkg::*;
#(
  parameter int GRLEN = 32
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    ecl_lsu_valid_e,
  input  logic [LSU_CODE_BIT-1:0] ecl_lsu_op_e,
  input  logic [GRLEN-1:0]        ecl_lsu_base_e,
  input  logic [GRLEN-1:0]        ecl_lsu_offset_e,
  input  logic [GRLEN-1:0]        ecl_lsu_wdata_e,
  input  logic [4:0]              ecl_lsu_rd_e,
  input  logic                    ecl_lsu_wen_e,
  output logic                    lsu_biu_req,
  output logic                    lsu_biu_wr,
  output logic [1:0]              lsu_biu_size,
  output logic [GRLEN-1:0]        lsu_biu_addr,
  output logic [3:0]              lsu_biu_wstrb,
  output logic [GRLEN-1:0]        lsu_biu_wdata,
  input  logic                    biu_lsu_addr_ok,
  input  logic                    biu_lsu_data_ok,
  input  logic [GRLEN-1:0]        biu_lsu_rdata,
  output logic [GRLEN-1:0]        lsu_ecl_rdata_m,
  output logic                    lsu_ecl_rdata_valid_m,
  output logic [4:0]              lsu_ecl_rd_m,
  output logic                    lsu_ecl_wen_m,
  output logic                    lsu_ecl_ale_m
);

  lsu_state_e state, state_nxt;

  logic [GRLEN-1:0]        addr_e;
  logic [GRLEN-1:0]        lane_wdata;
  logic [3:0]              lane_wstrb;
  logic [1:0]              size_e;
  logic                    is_load_e;
  logic                    misaligned_e;
  logic [GRLEN-1:0]        ld_result;
  logic [LSU_CODE_BIT-1:0] op_q;
  logic                    is_load_q;
  logic                    wen_q;
  logic [4:0]              rd_q;
  logic                    accept;
  logic                    complete;

  assign addr_e = ecl_lsu_base_e + ecl_lsu_offset_e;
  assign accept = (state == ST_IDLE) && ecl_lsu_valid_e;

  cpu7_lsu_align #(.GRLEN(GRLEN)) u_align (
    .st_op      (ecl_lsu_op_e),
    .st_addr_lo (addr_e[1:0]),
    .st_wdata   (ecl_lsu_wdata_e),
    .lane_wdata (lane_wdata),
    .lane_wstrb (lane_wstrb),
    .size       (size_e),
    .is_load    (is_load_e),
    .misaligned (misaligned_e),
    .ld_op      (op_q),
    .ld_addr_lo (lsu_biu_addr[1:0]),
    .rdata      (biu_lsu_rdata),
    .ld_result  (ld_result)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    lsu_biu_req = 1'b0;
    complete    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ecl_lsu_valid_e) begin
          if (misaligned_e) begin
            state_nxt = ST_DONE;
            complete  = 1'b1;
          end else begin
            state_nxt = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        lsu_biu_req = 1'b1;
        if (biu_lsu_addr_ok) begin
          if (biu_lsu_data_ok) begin
            state_nxt = ST_DONE;
            complete  = 1'b1;
          end else begin
            state_nxt = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (biu_lsu_data_ok) begin
          state_nxt = ST_DONE;
          complete  = 1'b1;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Bus-side fields are captured once at dispatch and held for the whole request.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op_q          <= '0;
      is_load_q     <= 1'b0;
      wen_q         <= 1'b0;
      rd_q          <= 5'd0;
      lsu_biu_addr  <= '0;
      lsu_biu_size  <= 2'd0;
      lsu_biu_wr    <= 1'b0;
      lsu_biu_wstrb <= 4'b0000;
      lsu_biu_wdata <= '0;
    end else if (accept) begin
      op_q          <= ecl_lsu_op_e;
      is_load_q     <= is_load_e;
      wen_q         <= ecl_lsu_wen_e;
      rd_q          <= ecl_lsu_rd_e;
      lsu_biu_addr  <= addr_e;
      lsu_biu_size  <= size_e;
      lsu_biu_wr    <= ~is_load_e;
      lsu_biu_wstrb <= lane_wstrb;
      lsu_biu_wdata <= lane_wdata;
    end
  end

  // Completion from IDLE can only be the misaligned shortcut.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lsu_ecl_rdata_valid_m <= 1'b0;
      lsu_ecl_rdata_m       <= '0;
      lsu_ecl_rd_m          <= 5'd0;
      lsu_ecl_wen_m         <= 1'b0;
      lsu_ecl_ale_m         <= 1'b0;
    end else begin
      lsu_ecl_rdata_valid_m <= complete;
      if (complete) begin
        if (state == ST_IDLE) begin
          lsu_ecl_rdata_m <= '0;
          lsu_ecl_rd_m    <= ecl_lsu_rd_e;
          lsu_ecl_wen_m   <= 1'b0;
          lsu_ecl_ale_m   <= 1'b1;
        end else begin
          lsu_ecl_rdata_m <= is_load_q ? ld_result : '0;
          lsu_ecl_rd_m    <= rd_q;
          lsu_ecl_wen_m   <= wen_q & is_load_q;
          lsu_ecl_ale_m   <= 1'b0;
        end
      end
    end
  end

endmodule

`default_nettype wire
